// File: rtl/pixgen_pkg.sv
// Shared types and constants for the pixstream_gen test-pattern source.
// Holds the pattern/state encodings and the Galois LFSR step used by the random pattern.
package pixgen_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [23:0] LFSR_SEED = 24'hACE1E5;
  localparam logic [23:0] LFSR_TAPS = 24'hE10000;

  // Right-shifting Galois step: the bit shifted out folds back through the taps.
  function automatic logic [23:0] lfsr_step(input logic [23:0] v);
    return {1'b0, v[23:1]} ^ (v[0] ? LFSR_TAPS : 24'h000000);
  endfunction

  function automatic logic all_lit(input logic [23:0] p);
    return (p[23:16] != 8'h00) && (p[15:8] != 8'h00) && (p[7:0] != 8'h00);
  endfunction

endpackage

// File: rtl/pixgen_lfsr.sv
// 24-bit Galois LFSR holding the value of the most recently emitted random pixel.
// nxt is the value the following pixel will carry.
module pixgen_lfsr
  import pixgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [23:0] nxt
);

  logic [23:0] lfsr_q;
  logic [23:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = LFSR_SEED;
    end else if (adv) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign nxt = lfsr_step(lfsr_q);

endmodule

// File: rtl/pixstream_gen.sv
// Frame-based RGB test-pattern source with black horizontal blanking and a golden
// count of emitted pixels whose three channels are all non-zero.
module pixstream_gen
  import pixgen_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int HBLANK = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [23:0] color,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        pix_valid,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        busy,
  output logic        done,
  output logic [31:0] lit_count,
  output logic [1:0]  dbg_state
);

  // Stream contract: pix_valid qualifies r/g/b/sof/eol/eof for exactly one cycle and
  // there is no ready; the consumer samples every clock and must take every pixel.

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int BW = (HBLANK > 0) ? $clog2(HBLANK + 1) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [BW-1:0] B_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] blk_q, blk_d;
  mode_e         mode_q, mode_d;
  logic [23:0]   color_q, color_d;
  logic [23:0]   pix_q, pix_d;
  logic [31:0]   lit_q, lit_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept;
  logic          x3, x4, y3;
  logic [23:0]   lfsr_nxt;

  assign accept = (state_q == IDLE) && start;

  pixgen_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .adv   ((state_d == ACTIVE) && !accept),
    .nxt   (lfsr_nxt)
  );

  // The parameter HBLANK shadows the state name, so the state is referenced by package.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    blk_d   = blk_q;
    mode_d  = mode_q;
    color_d = color_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          mode_d  = mode_e'(mode);
          color_d = color;
        end
      end
      ACTIVE: begin
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = DONE;
          end else if (HBLANK == 0) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            state_d = pixgen_pkg::HBLANK;
            blk_d   = '0;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      pixgen_pkg::HBLANK: begin
        if (blk_q == B_LAST) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = y_q + 1'b1;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pattern bits; masking instead of indexing keeps narrow counters (WIDTH<16) legal.
  always_comb begin
    x3 = |(x_d & XW'(8));
    x4 = |(x_d & XW'(16));
    y3 = |(y_d & YW'(8));
  end

  always_comb begin
    pix_d = 24'h000000;
    if (state_d == ACTIVE) begin
      unique case (mode_d)
        MODE_SOLID: pix_d = color_d;
        MODE_CHECK: pix_d = (x3 ^ y3) ? 24'h000000 : color_d;
        MODE_BARS:  pix_d = x4 ? 24'h000000 : color_d;
        MODE_LFSR:  pix_d = accept ? LFSR_SEED : lfsr_nxt;
        default:    pix_d = 24'h000000;
      endcase
    end
  end

  always_comb begin
    valid_d = (state_d == ACTIVE);
    sof_d   = valid_d && (x_d == '0) && (y_d == '0);
    eol_d   = valid_d && (x_d == X_LAST);
    eof_d   = eol_d && (y_d == Y_LAST);
    busy_d  = (state_d == ACTIVE) || (state_d == pixgen_pkg::HBLANK);
    done_d  = (state_d == DONE);
    lit_d   = (accept ? 32'd0 : lit_q) + 32'(valid_d && all_lit(pix_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      blk_q   <= '0;
      mode_q  <= MODE_SOLID;
      color_q <= 24'h000000;
      pix_q   <= 24'h000000;
      lit_q   <= 32'd0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      blk_q   <= blk_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      pix_q   <= pix_d;
      lit_q   <= lit_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign r         = pix_q[23:16];
  assign g         = pix_q[15:8];
  assign b         = pix_q[7:0];
  assign pix_valid = valid_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lit_count = lit_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pixstream_gen.sv
// Bench for pixstream_gen: two instances (8x4 with blanking, 16x16 without) checked
// by per-instance expected-pixel queues and frame-level timing checks.
module tb_pixstream_gen;

  localparam int AW = 8;
  localparam int AH = 4;
  localparam int AB = 2;
  localparam int BWD = 16;
  localparam int BHT = 16;
  localparam int BBL = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start, b_start;
  logic [1:0]  a_mode, b_mode;
  logic [23:0] a_color, b_color;
  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic        a_valid, a_sof, a_eol, a_eof, a_busy, a_done;
  logic        b_valid, b_sof, b_eol, b_eof, b_busy, b_done;
  logic [31:0] a_lit, b_lit;
  logic [1:0]  a_dbg, b_dbg;

  pixstream_gen #(.WIDTH(AW), .HEIGHT(AH), .HBLANK(AB)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode), .color(a_color),
    .r(a_r), .g(a_g), .b(a_b), .pix_valid(a_valid), .sof(a_sof), .eol(a_eol),
    .eof(a_eof), .busy(a_busy), .done(a_done), .lit_count(a_lit), .dbg_state(a_dbg)
  );

  pixstream_gen #(.WIDTH(BWD), .HEIGHT(BHT), .HBLANK(BBL)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .color(b_color),
    .r(b_r), .g(b_g), .b(b_b), .pix_valid(b_valid), .sof(b_sof), .eol(b_eol),
    .eof(b_eof), .busy(b_busy), .done(b_done), .lit_count(b_lit), .dbg_state(b_dbg)
  );

  // scoreboard: {sof, eol, eof, r, g, b}
  logic [26:0] exp_a_q[$];
  logic [26:0] exp_b_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_valid) begin
        if (exp_a_q.size() == 0) check("a_unexpected_pixel", 1, 0);
        else check("a_pixel", {a_sof, a_eol, a_eof, a_r, a_g, a_b}, exp_a_q.pop_front());
      end else if (a_busy || a_done) begin
        check("a_blank_black", {a_sof, a_eol, a_eof, a_r, a_g, a_b}, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_valid) begin
        if (exp_b_q.size() == 0) check("b_unexpected_pixel", 1, 0);
        else check("b_pixel", {b_sof, b_eol, b_eof, b_r, b_g, b_b}, exp_b_q.pop_front());
      end else if (b_busy || b_done) begin
        check("b_blank_black", {b_sof, b_eol, b_eof, b_r, b_g, b_b}, 0);
      end
    end
  end

  // driver: push the expected frame, request it, then time it against the reference
  task automatic run_frame(input int inst, input logic [1:0] m, input logic [23:0] c,
                           input bit hold_start);
    int w, h, hb, lit_exp, t_sof, t_eof, t_done, n_valid;
    logic [23:0] lf, px;
    logic first_lit, v, s, e, d, bz;
    logic [31:0] lc;
    w  = (inst == 0) ? AW : BWD;
    h  = (inst == 0) ? AH : BHT;
    hb = (inst == 0) ? AB : BBL;
    lf = 24'hACE1E5;
    lit_exp = 0;
    first_lit = 1'b0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        case (m)
          2'd0: px = c;
          2'd1: px = (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 24'h0 : c;
          2'd2: px = ((x >> 4) & 1) != 0 ? 24'h0 : c;
          default: begin
            px = lf;
            lf = {1'b0, lf[23:1]} ^ (lf[0] ? 24'hE10000 : 24'h0);
          end
        endcase
        if (px[23:16] != 0 && px[15:8] != 0 && px[7:0] != 0) begin
          lit_exp++;
          if (x == 0 && y == 0) first_lit = 1'b1;
        end
        if (inst == 0)
          exp_a_q.push_back({x == 0 && y == 0, x == w - 1, x == w - 1 && y == h - 1, px});
        else
          exp_b_q.push_back({x == 0 && y == 0, x == w - 1, x == w - 1 && y == h - 1, px});
      end
    end
    @(posedge clk); #1;
    if (inst == 0) begin a_start = 1'b1; a_mode = m; a_color = c; end
    else begin b_start = 1'b1; b_mode = m; b_color = c; end
    @(posedge clk); #1;
    // inputs move immediately after acceptance; the latched frame must not notice
    if (inst == 0) begin a_start = hold_start; a_mode = ~m; a_color = ~c; end
    else begin b_start = hold_start; b_mode = ~m; b_color = ~c; end
    t_sof = -1; t_eof = -1; t_done = -1; n_valid = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      v  = (inst == 0) ? a_valid : b_valid;
      s  = (inst == 0) ? a_sof : b_sof;
      e  = (inst == 0) ? a_eof : b_eof;
      d  = (inst == 0) ? a_done : b_done;
      bz = (inst == 0) ? a_busy : b_busy;
      lc = (inst == 0) ? a_lit : b_lit;
      if (t == 0) check("first_pixel_latency", {v, s, bz}, 3'b111);
      if (v) n_valid++;
      if (s) begin
        t_sof = t;
        check("lit_cleared_at_sof", lc, 32'(first_lit));
      end
      if (e) t_eof = t;
      if (d) begin
        t_done = t;
        check("busy_low_at_done", bz, 0);
        check("lit_count_at_done", lc, lit_exp);
        break;
      end
    end
    check("done_seen", t_done >= 0, 1);
    check("valid_pixel_count", n_valid, w * h);
    check("sof_to_eof_cycles", t_eof - t_sof + 1, w * h + (h - 1) * hb);
    check("done_after_eof", t_done - t_eof, 1);
  endtask

  initial begin
    a_start = 0; a_mode = 0; a_color = 0;
    b_start = 0; b_mode = 0; b_color = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a_pixel", {a_r, a_g, a_b}, 0);
    check("reset_a_flags", {a_valid, a_sof, a_eol, a_eof, a_busy, a_done}, 0);
    check("reset_a_lit", a_lit, 0);
    check("reset_a_state", a_dbg, 0);
    check("reset_b_flags", {b_valid, b_sof, b_eol, b_eof, b_busy, b_done}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_frame(0, 2'd0, 24'h102030, 1'b0);
    run_frame(0, 2'd0, 24'h00FF00, 1'b0);
    run_frame(1, 2'd1, 24'hFFFFFF, 1'b0);
    run_frame(0, 2'd3, 24'h000000, 1'b0);
    // start held high through a frame, then accepted again right after done
    run_frame(0, 2'd0, 24'h0A0B0C, 1'b1);
    run_frame(0, 2'd1, 24'h010101, 1'b0);

    // abort mid-line with an asynchronous reset
    for (int x = 0; x < AW; x++)
      exp_a_q.push_back({x == 0, x == AW - 1, 1'b0, 24'h112233});
    @(posedge clk); #1 a_start = 1'b1; a_mode = 2'd0; a_color = 24'h112233;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_a_q.delete();
    @(negedge clk);
    check("abort_pixel", {a_r, a_g, a_b}, 0);
    check("abort_flags", {a_valid, a_sof, a_eol, a_eof, a_busy, a_done}, 0);
    check("abort_lit", a_lit, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_abort_quiet", {a_valid, a_busy, a_done}, 0);
    end
    run_frame(0, 2'd2, 24'h445566, 1'b0);

    repeat (3) @(negedge clk);
    check("a_queue_drained", exp_a_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
